// File: rtl/ram_lsu_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_lsu_bridge_pkg
// Description : Shared types, encodings and helpers for the RAM load/store
//               bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_lsu_bridge_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_X = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        WriteEnable = 1'b1;

    // Illegal size or a byte offset that does not match the access width.
    function automatic logic lsu_size_fault(input lsu_size_e size,
                                            input logic [1:0] offset);
        logic fault;
        case (size)
            SIZE_B:  fault = 1'b0;
            SIZE_H:  fault = offset[0];
            SIZE_W:  fault = (offset != 2'b00);
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_lsu_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_lsu_bridge_if
// Description : Request/response and RAM-port signal bundle for the bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_lsu_bridge_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [31:0]       req_wdata_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_err_o;

    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [31:0]       ram_wdata_o;
    logic [31:0]       ram_rdata_i;

    // Bridge side
    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i,
        input  req_unsigned_i, rsp_ready_i, ram_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output ram_we_o, ram_addr_o, ram_wdata_o
    );

    // Core + RAM side
    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i,
        output req_unsigned_i, rsp_ready_i, ram_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  ram_we_o, ram_addr_o, ram_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/ram_lsu_bridge_lane_extract.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_extract
// Description : Selects the addressed byte/half lane of a RAM word and
//               sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_extract
    import ram_lsu_bridge_pkg::*;
(
    input  wire logic [31:0] i_rdata,
    input  wire logic [1:0]  i_offset,
    input  lsu_size_e        i_size,
    input  wire logic        i_unsigned,
    output logic [31:0]      o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_fill;

    always_comb begin
        w_byte = i_rdata[{i_offset, 3'b000} +: 8];
        w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];
        w_fill = 1'b0;
        o_data = i_rdata;
        case (i_size)
            SIZE_B: begin
                w_fill = ~i_unsigned & w_byte[7];
                o_data = {{24{w_fill}}, w_byte};
            end
            SIZE_H: begin
                w_fill = ~i_unsigned & w_half[15];
                o_data = {{16{w_fill}}, w_half};
            end
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ram_lsu_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ram_lsu_bridge
// Description : Load/store front-end for a word-addressed data RAM: lane
//               extraction for loads, read-modify-write for sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_lsu_bridge
    import ram_lsu_bridge_pkg::*;
#(
    parameter int MEM_NUM = 4096,
    parameter int ADDR_W  = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ram_lsu_bridge_if.slave  bus
);
    localparam logic [ADDR_W-1:0] c_MEM_NUM = ADDR_W'(MEM_NUM);

    lsu_state_e        r_state;
    lsu_state_e        w_state_next;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    lsu_size_e         r_size;
    logic              r_unsigned;
    logic [31:0]       r_merge;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;

    lsu_size_e         w_req_size;
    logic              w_accept;
    logic              w_req_err;
    logic              w_subword;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merged;
    logic [ADDR_W-1:0] w_word_addr;

    assign w_req_size      = lsu_size_e'(bus.req_size_i);
    assign bus.req_ready_o = (r_state == ST_IDLE) & ~rst;
    assign w_accept        = bus.req_valid_i & bus.req_ready_o;
    assign w_req_err       = lsu_size_fault(w_req_size, bus.req_addr_i[1:0])
                           | ({2'b00, bus.req_addr_i[ADDR_W-1:2]} >= c_MEM_NUM);
    assign w_subword       = (r_size != SIZE_W);
    assign w_word_addr     = {r_addr[ADDR_W-1:2], 2'b00};

    assign bus.rsp_valid_o = (r_state == ST_RESP);
    assign bus.rsp_rdata_o = r_rsp_rdata;
    assign bus.rsp_err_o   = r_rsp_err;

    lsu_lane_extract u_lane_extract (
        .i_rdata    (bus.ram_rdata_i),
        .i_offset   (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; faulting requests skip the RAM entirely.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_req_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_state_next = (r_we & w_subword) ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Sub-word store: replace only the addressed lane of the captured word.
    always_comb begin
        w_merged = r_merge;
        if (r_size == SIZE_B) begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    // RAM port drive; everything is forced quiet while rst is high.
    always_comb begin
        bus.ram_we_o    = 1'b0;
        bus.ram_addr_o  = '0;
        bus.ram_wdata_o = ZeroWord;
        if (!rst) begin
            case (r_state)
                ST_ACCESS: begin
                    bus.ram_addr_o = w_word_addr;
                    if (r_we && !w_subword) begin
                        bus.ram_we_o    = WriteEnable;
                        bus.ram_wdata_o = r_wdata;
                    end
                end
                ST_WRITE: begin
                    bus.ram_addr_o  = w_word_addr;
                    bus.ram_we_o    = WriteEnable;
                    bus.ram_wdata_o = w_merged;
                end
                default: begin
                    bus.ram_addr_o = '0;
                end
            endcase
        end
    end

    // Request capture and response datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= ZeroWord;
            r_size      <= SIZE_B;
            r_unsigned  <= 1'b0;
            r_merge     <= ZeroWord;
            r_rsp_rdata <= ZeroWord;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we        <= bus.req_we_i;
                r_addr      <= bus.req_addr_i;
                r_wdata     <= bus.req_wdata_i;
                r_size      <= w_req_size;
                r_unsigned  <= bus.req_unsigned_i;
                r_rsp_rdata <= ZeroWord;
                r_rsp_err   <= w_req_err;
            end
            if (r_state == ST_ACCESS) begin
                if (!r_we) begin
                    r_rsp_rdata <= w_load_data;
                end else if (w_subword) begin
                    r_merge <= bus.ram_rdata_i;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_lsu_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_lsu_bridge
// Description : Randomized self-checking bench for ram_lsu_bridge against a
//               transaction-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ram_lsu_bridge;
    localparam int MEM_NUM = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ram_clear = 1'b1;
    always #5 clk = ~clk;

    ram_lsu_bridge_if #(.ADDR_W(32)) bus();

    ram_lsu_bridge #(.MEM_NUM(MEM_NUM), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM attached to the bridge
    logic [31:0] mem     [0:MEM_NUM-1];
    logic [31:0] ref_mem [0:MEM_NUM-1];

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < MEM_NUM; i++) mem[i] <= '0;
        end else if (bus.ram_we_o) begin
            mem[bus.ram_addr_o[13:2]] <= bus.ram_wdata_o;
        end
    end
    assign bus.ram_rdata_i = mem[bus.ram_addr_o[13:2]];

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        bit          we_exp;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } exp_t;

    exp_t expq[$];

    // Transaction-level reference: what a request must produce given ref_mem.
    function automatic exp_t model(input bit we, input logic [31:0] a, input logic [31:0] wd,
                                   input logic [1:0] sz, input bit uns);
        exp_t e;
        logic [31:0] w, v, mask;
        int sh;
        e.we_exp = 0; e.waddr = '0; e.wdata = '0; e.rdata = '0; e.lat = 1;
        e.err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
              || ((a >> 2) >= MEM_NUM);
        if (!e.err) begin
            w    = ref_mem[a[13:2]];
            sh   = 8 * int'(a[1:0]);
            mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
            if (!we) begin
                e.lat = 2;
                v = (w >> sh) & mask;
                if (!uns && sz == 2'd0 && v >= 32'h80)   v = v + 32'hFFFF_FF00;
                if (!uns && sz == 2'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
                e.rdata = v;
            end else begin
                e.we_exp = 1;
                e.waddr  = {a[31:2], 2'b00};
                e.lat    = (sz == 2'd2) ? 2 : 3;
                e.wdata  = (w & ~(mask << sh)) | ((wd & mask) << sh);
            end
        end
        return e;
    endfunction

    // Compare process: checks every cycle against the model's expectation.
    int   cyc = 0;
    bit   busy = 0;
    bit   started = 0;
    int   acc = 0;
    exp_t cur;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bit ev, ew;
        if (rst) begin
            if (started) begin
                chk("rst_ram_we",    32'(bus.ram_we_o),    32'd0);
                chk("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
                chk("rst_ram_addr",  bus.ram_addr_o,       32'd0);
            end
            started = 1;
            busy    = 0;
        end else if (started) begin
            chk("req_ready", 32'(bus.req_ready_o), 32'(!busy));
            ev = busy && ((cyc - acc) >= cur.lat);
            chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(ev));
            ew = busy && cur.we_exp && ((cyc - acc) == cur.lat - 1);
            chk("ram_we", 32'(bus.ram_we_o), 32'(ew));
            if (ew) begin
                chk("ram_addr",  bus.ram_addr_o,  cur.waddr);
                chk("ram_wdata", bus.ram_wdata_o, cur.wdata);
            end
            if (ev && bus.rsp_valid_o) begin
                chk("rsp_rdata", bus.rsp_rdata_o,      cur.rdata);
                chk("rsp_err",   32'(bus.rsp_err_o),   32'(cur.err));
            end
            if (busy && bus.rsp_valid_o && bus.rsp_ready_i) begin
                busy = 0;
            end else if (!busy && bus.req_valid_i && bus.req_ready_o) begin
                if (expq.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_accept: got accept expected none at %0t", $time);
                end else begin
                    cur  = expq.pop_front();
                    acc  = cyc;
                    busy = 1;
                end
            end
        end
    end

    // Called #1 after a posedge; returns #1 after a posedge.
    task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input bit uns, input int stall,
                          input bit abort_in_write, output exp_t e);
        bit ok;
        e = model(we, a, wd, sz, uns);
        expq.push_back(e);
        bus.req_we_i       = we;
        bus.req_addr_i     = a;
        bus.req_wdata_i    = wd;
        bus.req_size_i     = sz;
        bus.req_unsigned_i = uns;
        bus.req_valid_i    = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready_o) begin ok = 1; break; end
        end
        if (!ok) begin
            total_cnt++;
            $display("FAIL accept_timeout: got no ready expected ready within 20 cycles");
            bus.req_valid_i = 1'b0;
            void'(expq.pop_back());
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        if (abort_in_write) begin
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            return;
        end
        bus.rsp_ready_i = (stall == 0);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o) begin ok = 1; break; end
        end
        if (!ok) begin
            total_cnt++;
            $display("FAIL rsp_timeout: got no rsp_valid expected rsp_valid within 10 cycles");
            bus.rsp_ready_i = 1'b1;
            @(posedge clk); #1; rst = 1'b1;
            @(posedge clk); #1; rst = 1'b0;
            return;
        end
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1 bus.rsp_ready_i = 1'b1;
        end
        @(posedge clk); #1;
        if (e.we_exp) ref_mem[e.waddr[13:2]] = e.wdata;
    endtask

    initial begin
        exp_t e;
        int mism;
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_addr_i     = '0;
        bus.req_wdata_i    = '0;
        bus.req_size_i     = '0;
        bus.req_unsigned_i = 1'b0;
        bus.rsp_ready_i    = 1'b1;
        for (int i = 0; i < MEM_NUM; i++) ref_mem[i] = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0; ram_clear = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("reset_rsp_rdata", bus.rsp_rdata_o,      32'd0);
        chk("reset_rsp_err",   32'(bus.rsp_err_o),   32'd0);
        chk("reset_req_ready", 32'(bus.req_ready_o), 32'd1);
        @(posedge clk); #1;

        // Word store then load back
        do_req(1, 32'h10, 32'hDEAD_BEEF, 2'd2, 0, 0, 0, e);
        chk("pin_wstore_lat", e.lat, 32'd2);
        do_req(0, 32'h10, 32'h0, 2'd2, 0, 0, 0, e);
        chk("pin_wload", e.rdata, 32'hDEAD_BEEF);

        // Byte store read-modify-write
        do_req(1, 32'h20, 32'h1122_3344, 2'd2, 0, 0, 0, e);
        do_req(1, 32'h22, 32'h0000_00AA, 2'd0, 0, 0, 0, e);
        chk("pin_bstore_data", e.wdata, 32'h11AA_3344);
        chk("pin_bstore_lat",  e.lat,   32'd3);

        // Lane extraction and extension
        do_req(1, 32'h30, 32'h80F0_017F, 2'd2, 0, 0, 0, e);
        do_req(0, 32'h33, 32'h0, 2'd0, 0, 0, 0, e);
        chk("pin_lb_s",  e.rdata, 32'hFFFF_FF80);
        do_req(0, 32'h33, 32'h0, 2'd0, 1, 0, 0, e);
        chk("pin_lb_u",  e.rdata, 32'h0000_0080);
        do_req(0, 32'h30, 32'h0, 2'd1, 0, 0, 0, e);
        chk("pin_lh_lo", e.rdata, 32'h0000_017F);
        do_req(0, 32'h32, 32'h0, 2'd1, 0, 0, 0, e);
        chk("pin_lh_hi", e.rdata, 32'hFFFF_80F0);

        // Faulting requests
        do_req(0, 32'h41, 32'h0, 2'd1, 0, 0, 0, e);
        chk("pin_err_half", 32'(e.err), 32'd1);
        do_req(1, 32'h42, 32'h1234, 2'd2, 0, 0, 0, e);
        chk("pin_err_word", 32'(e.err), 32'd1);
        do_req(0, 32'h30, 32'h0, 2'd3, 0, 0, 0, e);
        chk("pin_err_size", 32'(e.err), 32'd1);
        do_req(0, 32'(MEM_NUM * 4), 32'h0, 2'd2, 0, 0, 0, e);
        chk("pin_err_range", 32'(e.err), 32'd1);
        chk("pin_err_lat",   e.lat,      32'd1);

        // Response back-pressure
        do_req(0, 32'h30, 32'h0, 2'd2, 0, 5, 0, e);

        // Reset during the write cycle of a byte store
        do_req(1, 32'h21, 32'h55, 2'd0, 0, 0, 1, e);
        @(negedge clk);
        chk("abort_ram_word", mem[8], 32'h11AA_3344);
        @(posedge clk); #1;
        do_req(0, 32'h20, 32'h0, 2'd2, 0, 0, 0, e);
        chk("pin_after_abort", e.rdata, 32'h11AA_3344);

        // Random traffic
        for (int n = 0; n < 200; n++) begin
            int m;
            logic [31:0] a;
            logic [1:0]  sz;
            m  = $urandom_range(0, 9);
            a  = (m == 0) ? (32'h4000 + 32'($urandom_range(0, 255))) : 32'($urandom_range(0, 255));
            m  = $urandom_range(0, 9);
            sz = (m == 9) ? 2'd3 : 2'(m % 3);
            do_req(1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), 0, e);
        end

        mism = 0;
        for (int i = 0; i < MEM_NUM; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("ram_contents", mism, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
